// File: rtl/wb_timer_slave.sv
// wb_timer_slave: 8-bit Wishbone responder wrapping a 16-bit down-counting
// timer with an 8-bit prescaler, overflow flag and level interrupt.
module wb_timer_slave #(
  parameter logic [15:0] BASE       = 16'hF000,
  parameter logic [15:0] RELOAD_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_i,
  input  logic [7:0]  dat_i,
  output logic [7:0]  dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_RELL   = 3'd2;
  localparam logic [2:0] OFF_RELH   = 3'd3;
  localparam logic [2:0] OFF_CNTL   = 3'd4;
  localparam logic [2:0] OFF_CNTH   = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;

  // ctrl bit positions
  localparam int EN    = 0;
  localparam int AUTO  = 1;
  localparam int IRQEN = 2;

  logic        ack_q,    ack_d;
  logic [7:0]  dat_q,    dat_d;
  logic        irq_q,    irq_d;
  logic [2:0]  ctrl_q,   ctrl_d;
  logic [7:0]  presc_q,  presc_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q,  count_d;
  logic        ovf_q,    ovf_d;
  logic [7:0]  pcnt_q,   pcnt_d;
  logic [7:0]  shadow_q, shadow_d;

  logic       sel, acc, wr, rd, tick;
  logic [2:0] off;

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign irq_o = irq_q;

  // Bus decode, register file, prescaler and counter next-state
  always_comb begin
    sel  = cyc_i & stb_i & (addr_i[15:3] == BASE[15:3]);
    off  = addr_i[2:0];
    // the edge that raises ack is the one that performs the access
    acc  = sel & ~ack_q;
    wr   = acc & we_i;
    rd   = acc & ~we_i;
    tick = ctrl_q[EN] & (pcnt_q == presc_q);

    ack_d    = acc;
    dat_d    = 8'h00;
    irq_d    = ovf_q & ctrl_q[IRQEN];
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    shadow_d = shadow_q;

    // prescaler: held at 0 while disabled, wraps on tick (or at 255)
    if (!ctrl_q[EN])  pcnt_d = 8'h00;
    else if (tick)    pcnt_d = 8'h00;
    else              pcnt_d = pcnt_q + 8'd1;

    if (rd) begin
      case (off)
        OFF_CTRL:   dat_d = {5'b0, ctrl_q};
        OFF_PRESC:  dat_d = presc_q;
        OFF_RELL:   dat_d = reload_q[7:0];
        OFF_RELH:   dat_d = reload_q[15:8];
        OFF_CNTL: begin
          dat_d    = count_q[7:0];
          shadow_d = count_q[15:8];
        end
        OFF_CNTH:   dat_d = shadow_q;
        OFF_STATUS: dat_d = {7'b0, ovf_q};
        default:    dat_d = 8'h00;
      endcase
    end

    // clear first so a same-edge overflow set wins
    if (wr && off == OFF_STATUS && dat_i[0]) ovf_d = 1'b0;
    if (wr && off == OFF_PRESC) presc_d = dat_i;
    if (wr && off == OFF_RELL)  reload_d[7:0]  = dat_i;
    if (wr && off == OFF_RELH)  reload_d[15:8] = dat_i;

    if (tick) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'd1;
      end else begin
        ovf_d = 1'b1;
        if (ctrl_q[AUTO]) count_d    = reload_q;
        else              ctrl_d[EN] = 1'b0;
      end
    end

    // CTRL write overrides the one-shot auto-disable; a rising EN restarts
    if (wr && off == OFF_CTRL) begin
      ctrl_d = dat_i[2:0];
      if (dat_i[EN] && !ctrl_q[EN]) begin
        count_d = reload_q;
        pcnt_d  = 8'h00;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      irq_q    <= 1'b0;
      ctrl_q   <= 3'b000;
      presc_q  <= 8'h00;
      reload_q <= RELOAD_RST;
      count_q  <= 16'h0000;
      ovf_q    <= 1'b0;
      pcnt_q   <= 8'h00;
      shadow_q <= 8'h00;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_wb_timer_slave.sv
// Bench for wb_timer_slave: register access, decode, timer periods,
// atomic count read and same-edge collisions against an arithmetic model.
module tb_wb_timer_slave;

  localparam logic [15:0] BASE = 16'hF000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_i;
  logic [7:0]  dat_i, dat_o;
  logic        we_i, stb_i, cyc_i, ack_o, irq_o;

  int n_pass = 0, n_total = 0;
  int cyc_cnt = 0;
  int last_waits, last_edge;
  logic [7:0] last_wdat;

  wb_timer_slave #(.BASE(BASE), .RELOAD_RST(16'h0000)) dut (
    .clk(clk), .reset(reset), .addr_i(addr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // one Wishbone access; returns the data seen on the ack cycle
  task automatic bus(input logic w, input logic [2:0] off, input logic [7:0] d,
                     output logic [7:0] r);
    int g;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w;
    addr_i = BASE | {13'h0, off}; dat_i = d;
    @(posedge clk); #1; g = 1;
    while (!ack_o && g < 8) begin @(posedge clk); #1; g++; end
    r = dat_o; last_waits = g; last_edge = cyc_cnt;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (!ack_o) begin
      n_total++;
      $display("FAIL bus_ack: no ack at offset %0d after %0d cycles", off, g);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] r;
    bus(1'b1, off, d, r);
    last_wdat = r;
  endtask

  task automatic rdr(input logic [2:0] off, output logic [7:0] d);
    bus(1'b0, off, 8'h00, d);
  endtask

  task automatic idle_to(input int c);
    int g = 0;
    while (cyc_cnt < c && g < 100000) begin @(posedge clk); #1; g++; end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    addr_i = 16'h0000; dat_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ack_o !== 1'b0) $display("FAIL reset_ack: got %b exp 0", ack_o); else n_pass++;
    n_total++; if (dat_o !== 8'h00) $display("FAIL reset_dat: got %h exp 00", dat_o); else n_pass++;
    n_total++; if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b exp 0", irq_o); else n_pass++;
    reset = 1'b0;
    for (int o = 0; o < 8; o++) begin
      @(posedge clk); #1;
      rdr(3'(o), v);
      n_total++; if (last_waits !== 1) $display("FAIL reset_wait off%0d: got %0d exp 1", o, last_waits); else n_pass++;
      n_total++; if (v !== 8'h00) $display("FAIL reset_read off%0d: got %h exp 00", o, v); else n_pass++;
    end
  endtask

  // back-to-back random register traffic with the timer disabled
  task automatic test_regs;
    logic [7:0] m_ctrl = 8'h00, m_presc = 8'h00, m_rl = 8'h00, m_rh = 8'h00;
    logic [7:0] d, v, e;
    int off;
    for (int i = 0; i < 24; i++) begin
      off = int'($urandom_range(7, 0));
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        if (off == 0) d = d & 8'hFE;
        wr(3'(off), d);
        case (off)
          0: m_ctrl  = d & 8'h06;
          1: m_presc = d;
          2: m_rl    = d;
          3: m_rh    = d;
          default: ;
        endcase
        n_total++; if (last_wdat !== 8'h00) $display("FAIL regs_wdat off%0d: got %h exp 00", off, last_wdat); else n_pass++;
      end else begin
        rdr(3'(off), v);
        case (off)
          0: e = m_ctrl;
          1: e = m_presc;
          2: e = m_rl;
          3: e = m_rh;
          default: e = 8'h00;
        endcase
        n_total++; if (v !== e) $display("FAIL regs_read off%0d: got %h exp %h", off, v, e); else n_pass++;
      end
    end
  endtask

  task automatic test_decode;
    logic [7:0] v, r;
    int acks = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 16'hE000;
    repeat (10) begin @(posedge clk); #1; if (ack_o) acks++; end
    cyc_i = 1'b0; stb_i = 1'b0;
    n_total++; if (acks !== 0) $display("FAIL decode_unsel: got %0d acks exp 0", acks); else n_pass++;
    v = 8'($urandom);
    wr(3'd1, v);
    rdr(3'd1, r);
    n_total++; if (r !== v) $display("FAIL decode_rw: got %h exp %h", r, v); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (ack_o !== 1'b0) $display("FAIL ack_pulse: got %b exp 0", ack_o); else n_pass++;
    n_total++; if (dat_o !== 8'h00) $display("FAIL dat_idle: got %h exp 00", dat_o); else n_pass++;
    acks = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 16'hF001;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_o) begin
        acks++;
        n_total++; if (dat_o !== v) $display("FAIL held_dat: got %h exp %h", dat_o, v); else n_pass++;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    n_total++; if (acks !== 3) $display("FAIL held_acks: got %0d exp 3", acks); else n_pass++;
  endtask

  task automatic test_auto;
    int p, r, t, e, found, ovf_edge;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin p = 0; r = 3; end
      else begin p = int'($urandom_range(3, 0)); r = int'($urandom_range(6, 2)); end
      t = (r + 1) * (p + 1);
      wr(3'd0, 8'h00); wr(3'd6, 8'h01);
      wr(3'd1, 8'(p)); wr(3'd2, 8'(r)); wr(3'd3, 8'h00);
      wr(3'd0, 8'h07);
      e = last_edge;
      n_total++; if (irq_o !== 1'b0) $display("FAIL auto_irq_start it%0d: got %b exp 0", it, irq_o); else n_pass++;
      found = -1;
      for (int g = 0; g < 400 && found < 0; g++) begin
        @(posedge clk); #1;
        if (irq_o) found = cyc_cnt;
      end
      n_total++; if (found !== e + t + 1) $display("FAIL auto_irq_edge it%0d: got %0d exp %0d", it, found - e, t + 1); else n_pass++;
      ovf_edge = e + t;
      wr(3'd6, 8'h01);
      @(posedge clk); #1;
      n_total++; if (irq_o !== 1'b0) $display("FAIL auto_irq_clr it%0d: got %b exp 0", it, irq_o); else n_pass++;
      found = -1;
      for (int g = 0; g < 400 && found < 0; g++) begin
        @(posedge clk); #1;
        if (irq_o) found = cyc_cnt;
      end
      n_total++; if (found !== ovf_edge + t + 1) $display("FAIL auto_irq_again it%0d: got %0d exp %0d", it, found - ovf_edge, t + 1); else n_pass++;
    end
    wr(3'd0, 8'h00); wr(3'd6, 8'h01);
  endtask

  task automatic test_oneshot;
    int p, r, t, e;
    logic [7:0] v;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin p = 2; r = 1; end
      else begin p = int'($urandom_range(3, 0)); r = int'($urandom_range(5, 1)); end
      t = (r + 1) * (p + 1);
      wr(3'd0, 8'h00); wr(3'd6, 8'h01);
      wr(3'd1, 8'(p)); wr(3'd2, 8'(r)); wr(3'd3, 8'h00);
      wr(3'd0, 8'h01);
      e = last_edge;
      idle_to(e + t - 1);
      rdr(3'd6, v);   // samples state just before the overflow edge
      n_total++; if (v !== 8'h00) $display("FAIL oneshot_early it%0d: got %h exp 00", it, v); else n_pass++;
      rdr(3'd6, v);
      n_total++; if (v !== 8'h01) $display("FAIL oneshot_ovf it%0d: got %h exp 01", it, v); else n_pass++;
      rdr(3'd0, v);
      n_total++; if (v !== 8'h00) $display("FAIL oneshot_ctrl it%0d: got %h exp 00", it, v); else n_pass++;
      repeat (5) @(posedge clk);
      #1;
      rdr(3'd4, v);
      n_total++; if (v !== 8'h00) $display("FAIL oneshot_cntl it%0d: got %h exp 00", it, v); else n_pass++;
      rdr(3'd5, v);
      n_total++; if (v !== 8'h00) $display("FAIL oneshot_cnth it%0d: got %h exp 00", it, v); else n_pass++;
      n_total++; if (irq_o !== 1'b0) $display("FAIL oneshot_irq it%0d: got %b exp 0", it, irq_o); else n_pass++;
    end
    wr(3'd6, 8'h01);
  endtask

  // model: with AUTO, PRESC=0, RELOAD=256 the value after edge k is
  // 256 - ((k - E) mod 257)
  task automatic test_atomic;
    int e, x;
    logic [7:0] lo, hi;
    logic [15:0] exp_cnt;
    wr(3'd0, 8'h00); wr(3'd6, 8'h01);
    wr(3'd1, 8'h00); wr(3'd2, 8'h00); wr(3'd3, 8'h01);
    wr(3'd0, 8'h03);
    e = last_edge;
    for (int it = 0; it < 8; it++) begin
      if (it == 0)      x = e + 258;
      else if (it == 1) x = e + 257 + 258;
      else              x = cyc_cnt + int'($urandom_range(80, 2));
      idle_to(x - 1);
      rdr(3'd4, lo);
      x = last_edge;
      rdr(3'd5, hi);
      exp_cnt = 16'(256 - ((x - 1 - e) % 257));
      n_total++; if ({hi, lo} !== exp_cnt) $display("FAIL atomic_read it%0d: got %h exp %h", it, {hi, lo}, exp_cnt); else n_pass++;
    end
    wr(3'd0, 8'h00); wr(3'd6, 8'h01);
  endtask

  task automatic test_collision;
    int e;
    logic [7:0] v;
    // overflow set vs write-1 clear on the same edge
    wr(3'd0, 8'h00); wr(3'd6, 8'h01);
    wr(3'd1, 8'h00); wr(3'd2, 8'h02); wr(3'd3, 8'h00);
    wr(3'd0, 8'h07);
    e = last_edge;
    idle_to(e + 2);
    wr(3'd6, 8'h01);
    rdr(3'd6, v);
    n_total++; if (v !== 8'h01) $display("FAIL coll_setclr: got %h exp 01", v); else n_pass++;
    // EN=0 write on a one-shot overflow edge
    wr(3'd0, 8'h00); wr(3'd6, 8'h01);
    wr(3'd0, 8'h01);
    e = last_edge;
    idle_to(e + 2);
    wr(3'd0, 8'h00);
    rdr(3'd0, v);
    n_total++; if (v !== 8'h00) $display("FAIL coll_oneshot_ctrl: got %h exp 00", v); else n_pass++;
    rdr(3'd6, v);
    n_total++; if (v !== 8'h01) $display("FAIL coll_oneshot_ovf: got %h exp 01", v); else n_pass++;
    // CTRL write on an auto-reload edge: write wins, reload still happens
    wr(3'd6, 8'h01);
    wr(3'd0, 8'h03);
    e = last_edge;
    idle_to(e + 2);
    wr(3'd0, 8'h07);
    rdr(3'd4, v);
    n_total++; if (v !== 8'h01) $display("FAIL coll_reload_cnt: got %h exp 01", v); else n_pass++;
    rdr(3'd0, v);
    n_total++; if (v !== 8'h07) $display("FAIL coll_reload_ctrl: got %h exp 07", v); else n_pass++;
    wr(3'd0, 8'h00);
    // reset in the middle of a RELOAD_L write
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = BASE | 16'h0002; dat_i = 8'hAB;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++; if (ack_o !== 1'b0) $display("FAIL rst_mid_ack: got %b exp 0", ack_o); else n_pass++;
    reset = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    n_total++; if (irq_o !== 1'b0) $display("FAIL rst_mid_irq: got %b exp 0", irq_o); else n_pass++;
    @(posedge clk); #1;
    rdr(3'd2, v);
    n_total++; if (v !== 8'h00) $display("FAIL rst_mid_rell: got %h exp 00", v); else n_pass++;
    rdr(3'd3, v);
    n_total++; if (v !== 8'h00) $display("FAIL rst_mid_relh: got %h exp 00", v); else n_pass++;
    rdr(3'd0, v);
    n_total++; if (v !== 8'h00) $display("FAIL rst_mid_ctrl: got %h exp 00", v); else n_pass++;
    rdr(3'd6, v);
    n_total++; if (v !== 8'h00) $display("FAIL rst_mid_status: got %h exp 00", v); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_regs;
    test_decode;
    test_auto;
    test_oneshot;
    test_atomic;
    test_collision;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
